// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control unit with memory handshakes,
// registered ALU flags and a bounded return-stack occupancy counter.
module multicycle_controller #(
  parameter int IW          = 19,
  parameter int STACK_DEPTH = 8,
  parameter int SW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          imem_ready,
  input  logic          dmem_ready,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          imem_req,
  output logic          ir_write,
  output logic          pc_write,
  output logic [1:0]    pc_src,
  output logic          reg_write,
  output logic          const_en,
  output logic          reg_two_addr,
  output logic          mem_to_reg,
  output logic          dmem_req,
  output logic          mem_read,
  output logic          mem_write,
  output logic          push,
  output logic          pop,
  output logic [3:0]    alu_operation,
  output logic          flag_z,
  output logic          flag_c,
  output logic [SW-1:0] stack_count,
  output logic          halted,
  output logic          stack_err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_HALT,
    C_ARITH,
    C_IMM,
    C_SHIFT,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_CALL,
    C_RET,
    C_NOP
  } cls_t;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_STACK  = 2'd3;

  state_t     state;
  state_t     state_next;
  cls_t       cls;
  logic [5:0] op;
  logic [2:0] fn;
  logic [3:0] alu_op_cls;
  logic       branch_taken;
  logic       stack_full;
  logic       stack_empty;
  logic       trap;

  assign op          = instr[IW-1 -: 6];
  assign fn          = instr[IW-3 -: 3];
  assign stack_full  = (stack_count == SW'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);

  // Instruction class, first matching rule wins.
  always_comb begin
    cls = C_NOP;
    if (&instr) begin
      cls = C_HALT;
    end else if (op[5:4] == 2'b00) begin
      cls = C_ARITH;
    end else if (op[5:4] == 2'b01) begin
      cls = C_IMM;
    end else if (op[5:3] == 3'b110) begin
      cls = C_SHIFT;
    end else if (op[5:3] == 3'b100) begin
      if (op[2:1] == 2'b00) begin
        cls = C_LOAD;
      end else if (op[2:1] == 2'b01) begin
        cls = C_STORE;
      end else begin
        cls = C_NOP;
      end
    end else if (op[5:3] == 3'b101) begin
      cls = C_BRANCH;
    end else if (op[5:1] == 5'b11100) begin
      cls = C_JUMP;
    end else if (op[5:1] == 5'b11101) begin
      cls = C_CALL;
    end else if (op == 6'b111100) begin
      cls = C_RET;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    case (op[2:1])
      2'b00:   branch_taken = flag_z;
      2'b01:   branch_taken = ~flag_z;
      2'b10:   branch_taken = flag_c;
      default: branch_taken = ~flag_c;
    endcase
  end

  always_comb begin
    alu_op_cls = 4'b0000;
    case (cls)
      C_ARITH, C_IMM: alu_op_cls = {1'b0, fn};
      C_SHIFT:        alu_op_cls = {2'b10, fn[1:0]};
      default:        alu_op_cls = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Every strobe is forced low while rst is high, even though the state
  // register already sits in FETCH during reset.
  always_comb begin
    state_next    = state;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_INC;
    reg_write     = 1'b0;
    const_en      = 1'b0;
    reg_two_addr  = 1'b0;
    mem_to_reg    = 1'b0;
    dmem_req      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    alu_operation = 4'b0000;
    halted        = 1'b0;
    trap          = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_INC;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          state_next = S_FETCH;
          case (cls)
            C_ARITH, C_IMM, C_SHIFT: state_next = S_EXEC;
            C_LOAD, C_STORE:         state_next = S_MEM;
            C_BRANCH: begin
              if (branch_taken) begin
                pc_write = 1'b1;
                pc_src   = PC_BRANCH;
              end
            end
            C_JUMP: begin
              pc_write = 1'b1;
              pc_src   = PC_JUMP;
            end
            C_CALL: begin
              if (stack_full) begin
                trap       = 1'b1;
                state_next = S_HALT;
              end else begin
                push     = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
              end
            end
            C_RET: begin
              if (stack_empty) begin
                trap       = 1'b1;
                state_next = S_HALT;
              end else begin
                pop      = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_STACK;
              end
            end
            C_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
          endcase
        end
        S_EXEC: begin
          reg_write     = 1'b1;
          const_en      = (cls == C_IMM);
          alu_operation = alu_op_cls;
          state_next    = S_FETCH;
        end
        S_MEM: begin
          dmem_req     = 1'b1;
          reg_two_addr = 1'b1;
          const_en     = 1'b1;
          mem_to_reg   = 1'b1;
          mem_read     = (cls == C_LOAD);
          mem_write    = (cls == C_STORE);
          if (dmem_ready) begin
            reg_write  = (cls == C_LOAD);
            state_next = S_FETCH;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  // Flags only move on the edge that ends EXEC; the stack counter follows
  // the push/pop pulses, and a trap is remembered until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      stack_count <= '0;
      stack_err   <= 1'b0;
    end else begin
      if (state == S_EXEC) begin
        flag_z <= alu_zero;
        flag_c <= alu_carry;
      end
      if (push) begin
        stack_count <= stack_count + SW'(1);
      end else if (pop) begin
        stack_count <= stack_count - SW'(1);
      end
      if (trap) begin
        stack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus a random instruction stream,
// compared against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int IW    = 19;
  localparam int DEPTH = 2;
  localparam int SW    = $clog2(DEPTH + 1);

  localparam int K_HALT   = 0;
  localparam int K_ARITH  = 1;
  localparam int K_IMM    = 2;
  localparam int K_SHIFT  = 3;
  localparam int K_LOAD   = 4;
  localparam int K_STORE  = 5;
  localparam int K_BRANCH = 6;
  localparam int K_JUMP   = 7;
  localparam int K_CALL   = 8;
  localparam int K_RET    = 9;
  localparam int K_NOP    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          alu_zero = 1'b0;
  logic          alu_carry = 1'b0;
  logic          imem_req, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          reg_write, const_en, reg_two_addr, mem_to_reg;
  logic          dmem_req, mem_read, mem_write, push, pop;
  logic [3:0]    alu_operation;
  logic          flag_z, flag_c;
  logic [SW-1:0] stack_count;
  logic          halted, stack_err;

  multicycle_controller #(.IW(IW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .const_en(const_en), .reg_two_addr(reg_two_addr),
    .mem_to_reg(mem_to_reg), .dmem_req(dmem_req), .mem_read(mem_read),
    .mem_write(mem_write), .push(push), .pop(pop), .alu_operation(alu_operation),
    .flag_z(flag_z), .flag_c(flag_c), .stack_count(stack_count),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit m_z, m_c, m_err, m_halt;
  int m_count;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [9:0] strobes();
    return {imem_req, ir_write, pc_write, reg_write, dmem_req,
            mem_read, mem_write, push, pop, halted};
  endfunction

  function automatic logic [9:0] mk(input bit imr, irw, pcw, rw, dr, mr, mw, ps, pp, hl);
    return {imr, irw, pcw, rw, dr, mr, mw, ps, pp, hl};
  endfunction

  function automatic int classify(input logic [IW-1:0] w);
    logic [5:0] o;
    o = w[IW-1 -: 6];
    if (w == '1) return K_HALT;
    casez (o)
      6'b00????: return K_ARITH;
      6'b01????: return K_IMM;
      6'b110???: return K_SHIFT;
      6'b10000?: return K_LOAD;
      6'b10001?: return K_STORE;
      6'b100???: return K_NOP;
      6'b101???: return K_BRANCH;
      6'b11100?: return K_JUMP;
      6'b11101?: return K_CALL;
      6'b111100: return K_RET;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic logic [IW-1:0] mkInstr(input logic [5:0] o);
    logic [IW-7:0] r;
    r = (IW-6)'($urandom);
    return {o, r};
  endfunction

  task automatic modelReset();
    m_z = 0; m_c = 0; m_err = 0; m_halt = 0; m_count = 0;
  endtask

  // Called just after a rising edge; leaves the DUT in FETCH just after an edge.
  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_strobes", strobes(), 10'b0);
    checkOutput("rst_pc_src", pc_src, 0);
    checkOutput("rst_state", {stack_count, flag_z, flag_c, stack_err}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic randomiseSide();
    dmem_ready = 1'($urandom);
    alu_zero   = 1'($urandom);
    alu_carry  = 1'($urandom);
  endtask

  // Runs one instruction end to end; abort_mem asserts rst during the first MEM cycle.
  task automatic applyStimulus(input logic [IW-1:0] w, input int fwait, input int mwait,
                               input bit az, input bit ac, input bit abort_mem);
    int  k;
    bit  taken, last, ld, st;
    logic [3:0] exp_op;
    k = classify(w);
    for (int i = 0; i <= fwait; i++) begin
      instr = IW'($urandom);
      imem_ready = (i == fwait);
      randomiseSide();
      @(negedge clk);
      checkOutput("fetch", strobes(), mk(1, i == fwait, i == fwait, 0, 0, 0, 0, 0, 0, 0));
      if (i == fwait) checkOutput("fetch_src", pc_src, 0);
      @(posedge clk); #1;
    end
    instr = w;
    imem_ready = 1'($urandom);
    randomiseSide();
    @(negedge clk);
    checkOutput("dec_count", stack_count, m_count);
    checkOutput("dec_flags", {flag_z, flag_c}, {m_z, m_c});
    checkOutput("dec_err", stack_err, m_err);
    case (k)
      K_BRANCH: begin
        case (w[IW-4 -: 2])
          2'b00: taken = m_z;
          2'b01: taken = !m_z;
          2'b10: taken = m_c;
          default: taken = !m_c;
        endcase
        checkOutput("branch", strobes(), mk(0, 0, taken, 0, 0, 0, 0, 0, 0, 0));
        if (taken) checkOutput("branch_src", pc_src, 1);
      end
      K_JUMP: begin
        checkOutput("jump", strobes(), mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("jump_src", pc_src, 2);
      end
      K_CALL: begin
        if (m_count < DEPTH) begin
          checkOutput("call", strobes(), mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
          checkOutput("call_src", pc_src, 2);
          m_count++;
        end else begin
          checkOutput("call_trap", strobes(), 10'b0);
          m_err = 1; m_halt = 1;
        end
      end
      K_RET: begin
        if (m_count > 0) begin
          checkOutput("ret", strobes(), mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
          checkOutput("ret_src", pc_src, 3);
          m_count--;
        end else begin
          checkOutput("ret_trap", strobes(), 10'b0);
          m_err = 1; m_halt = 1;
        end
      end
      default: begin
        checkOutput("decode", strobes(), 10'b0);
        if (k == K_HALT) m_halt = 1;
      end
    endcase
    @(posedge clk); #1;

    if (k == K_ARITH || k == K_IMM || k == K_SHIFT) begin
      if (k == K_SHIFT) exp_op = {2'b10, w[IW-4 -: 2]};
      else              exp_op = {1'b0, w[IW-3 -: 3]};
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      alu_zero = az;
      alu_carry = ac;
      @(negedge clk);
      checkOutput("exec", strobes(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      checkOutput("exec_aluop", alu_operation, exp_op);
      checkOutput("exec_const", const_en, k == K_IMM);
      @(posedge clk); #1;
      m_z = az; m_c = ac;
    end

    if (k == K_LOAD || k == K_STORE) begin
      ld = (k == K_LOAD);
      st = (k == K_STORE);
      for (int i = 0; i <= mwait; i++) begin
        last = (i == mwait);
        imem_ready = 1'($urandom);
        alu_zero = 1'($urandom);
        alu_carry = 1'($urandom);
        dmem_ready = last;
        @(negedge clk);
        checkOutput("mem", strobes(), mk(0, 0, 0, ld && last, 1, ld, st, 0, 0, 0));
        checkOutput("mem_sel", {reg_two_addr, const_en}, 2'b11);
        if (last) checkOutput("mem_to_reg", mem_to_reg, 1);
        if (abort_mem) begin
          #1;
          rst = 1'b1;
          #1;
          checkOutput("rst_mem_dreq", dmem_req, 0);
          checkOutput("rst_mem_count", stack_count, 0);
          @(posedge clk); #1;
          rst = 1'b0;
          modelReset();
          return;
        end
        @(posedge clk); #1;
      end
    end

    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        imem_ready = 1'b1;
        randomiseSide();
        @(negedge clk);
        checkOutput("halt", strobes(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        checkOutput("halt_state", {stack_count, stack_err}, {SW'(m_count), m_err});
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IW-1:0] w;
    modelReset();
    @(posedge clk); #1;
    applyReset();

    // Reset while MEM waits, with a non-empty stack.
    applyStimulus(mkInstr(6'b111010), 1, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b100000), 0, 5, 0, 0, 1);

    // ALU fn=010 setting Z, then bz; shift fn=x11 setting C, then bnc.
    applyStimulus(mkInstr(6'b000100), 0, 0, 1, 0, 0);
    applyStimulus(mkInstr(6'b101000), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b110110), 0, 0, 0, 1, 0);
    applyStimulus(mkInstr(6'b101110), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b010110), 2, 0, 0, 0, 0);

    // Memory traffic: slow load, store, memory NOP, jump.
    applyStimulus(mkInstr(6'b100000), 0, 3, 0, 0, 0);
    applyStimulus(mkInstr(6'b100011), 1, 1, 0, 0, 0);
    applyStimulus(mkInstr(6'b100100), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b111001), 0, 0, 0, 0, 0);

    // Stack boundaries: fill, trap on overflow, trap on empty return.
    applyStimulus(mkInstr(6'b111010), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b111011), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b111010), 0, 0, 0, 0, 0);
    applyReset();
    applyStimulus(mkInstr(6'b111100), 0, 0, 0, 0, 0);
    applyReset();
    applyStimulus(mkInstr(6'b111010), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b111100), 0, 0, 0, 0, 0);
    applyStimulus(mkInstr(6'b000000), 0, 0, 1, 1, 0);
    w = '1;
    applyStimulus(w, 0, 0, 0, 0, 0);
    applyReset();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        w = mkInstr(($urandom_range(0, 1) == 0) ? 6'b111010 : 6'b111100);
      else
        w = IW'($urandom);
      applyStimulus(w, $urandom_range(0, 2), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), 0);
      if (m_halt) applyReset();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
